alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/regfile.sv | 38 +++
 rtl/alu_issue.sv | 176 +++++++++++++++++
 tb/tb_alu_issue.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants for the ALU issue block.
//   - Major opcodes handled by the issue stage.
//   - ALU function codes, packed as {func7, func3}.
//   - Issue FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;

  // Arithmetic / logic codes: the ten legal R-type {func7, func3} pairs.
  localparam logic [9:0] AluAdd  = {7'b0000000, 3'b000};
  localparam logic [9:0] AluSub  = {7'b0100000, 3'b000};
  localparam logic [9:0] AluSll  = {7'b0000000, 3'b001};
  localparam logic [9:0] AluSlt  = {7'b0000000, 3'b010};
  localparam logic [9:0] AluSltu = {7'b0000000, 3'b011};
  localparam logic [9:0] AluXor  = {7'b0000000, 3'b100};
  localparam logic [9:0] AluSrl  = {7'b0000000, 3'b101};
  localparam logic [9:0] AluSra  = {7'b0100000, 3'b101};
  localparam logic [9:0] AluOr   = {7'b0000000, 3'b110};
  localparam logic [9:0] AluAnd  = {7'b0000000, 3'b111};

  // Compare codes; the ALU answers these on logic_data.
  localparam logic [9:0] AluCmpEq  = {7'b1000000, 3'b100};
  localparam logic [9:0] AluCmpNe  = {7'b1000000, 3'b110};
  localparam logic [9:0] AluCmpLt  = {7'b1000000, 3'b001};
  localparam logic [9:0] AluCmpGe  = {7'b1100000, 3'b101};
  localparam logic [9:0] AluCmpLtu = {7'b1000000, 3'b111};
  localparam logic [9:0] AluCmpGeu = {7'b1000000, 3'b101};

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StRetire
  } state_e;

  // True for the R-type {func7, func3} pairs the ALU implements.
  function automatic logic is_alu_code(input logic [9:0] code);
    case (code)
      AluAdd, AluSub, AluSll, AluSlt, AluSltu,
      AluXor, AluSrl, AluSra, AluOr, AluAnd: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// 32-entry integer register file.
//   raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o : combinational operand reads
//   we_i, waddr_i, wdata_i                   : synchronous write port
//   dbg_addr_i/dbg_data_o                    : combinational debug read
// x0 always reads zero and ignores writes. Reset clears every entry.
module regfile #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [4:0]            raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [4:0]            raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [4:0]            dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == 5'd0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == 5'd0) ? '0 : mem_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of an external ALU for RV32I R/I/B instructions.
// One instruction at a time: IDLE (accept) -> EXEC (drive ALU) -> RETIRE (write back).
//   in_valid/in_ready/instr       : instruction handshake, accepted only in IDLE
//   func3/func7/rs1_data/rs2_data : ALU request, non-zero only in EXEC
//   rd_data/logic_data            : ALU response, sampled at the end of EXEC
//   retire_valid, branch_valid,
//   branch_taken, illegal         : one-cycle retire status in RETIRE
//   dbg_addr/dbg_data             : combinational register-file peek
module alu_issue
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  logic_data,
  output logic                  retire_valid,
  output logic                  branch_valid,
  output logic                  branch_taken,
  output logic                  illegal,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  state_e                state_q;
  logic [9:0]            code_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic [4:0]            rd_q;
  logic                  wr_q, br_q, ill_q;
  logic                  retire_q, branch_valid_q, branch_taken_q, illegal_q;

  logic [DATA_WIDTH-1:0] rs1_rdata, rs2_rdata;
  logic [9:0]            dec_code;
  logic [DATA_WIDTH-1:0] dec_op_a, dec_op_b;
  logic                  dec_wr, dec_br, dec_ill;

  regfile #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .raddr_a_i  (instr[19:15]),
    .rdata_a_o  (rs1_rdata),
    .raddr_b_i  (instr[24:20]),
    .rdata_b_o  (rs2_rdata),
    .we_i       ((state_q == StRetire) && wr_q),
    .waddr_i    (rd_q),
    .wdata_i    (result_q),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Decode of the incoming word; only consumed on the accepting IDLE cycle.
  always_comb begin
    dec_code = '0;
    dec_op_a = rs1_rdata;
    dec_op_b = rs2_rdata;
    dec_wr   = 1'b0;
    dec_br   = 1'b0;
    dec_ill  = 1'b0;
    case (instr[6:0])
      OpcodeOp: begin
        if (is_alu_code({instr[31:25], instr[14:12]})) begin
          dec_code = {instr[31:25], instr[14:12]};
          dec_wr   = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OpcodeOpImm: begin
        dec_wr   = 1'b1;
        dec_code = {7'b0000000, instr[14:12]};
        if ((instr[14:12] == 3'b101) && instr[30]) begin
          dec_code = AluSra;
        end
        // func3 001/101 are the shifts: operand is the zero-extended shamt.
        if (instr[13:12] == 2'b01) begin
          dec_op_b = DATA_WIDTH'(instr[24:20]);
        end else begin
          dec_op_b = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
        end
      end
      OpcodeBranch: begin
        case (instr[14:12])
          3'b000:  dec_code = AluCmpEq;
          3'b001:  dec_code = AluCmpNe;
          3'b100:  dec_code = AluCmpLt;
          3'b101:  dec_code = AluCmpGe;
          3'b110:  dec_code = AluCmpLtu;
          3'b111:  dec_code = AluCmpGeu;
          default: dec_ill  = 1'b1;
        endcase
        dec_br = !dec_ill;
      end
      default: dec_ill = 1'b1;
    endcase
    // Unsupported instructions present an all-zero request to the ALU.
    if (dec_ill) begin
      dec_op_a = '0;
      dec_op_b = '0;
    end
  end

  // Request registers are loaded on accept and cleared on leaving EXEC, so the
  // ALU outputs are zero everywhere except EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      code_q         <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      rd_q           <= '0;
      wr_q           <= 1'b0;
      br_q           <= 1'b0;
      ill_q          <= 1'b0;
      result_q       <= '0;
      retire_q       <= 1'b0;
      branch_valid_q <= 1'b0;
      branch_taken_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q <= StExec;
            code_q  <= dec_code;
            op_a_q  <= dec_op_a;
            op_b_q  <= dec_op_b;
            rd_q    <= instr[11:7];
            wr_q    <= dec_wr;
            br_q    <= dec_br;
            ill_q   <= dec_ill;
          end
        end
        StExec: begin
          state_q        <= StRetire;
          code_q         <= '0;
          op_a_q         <= '0;
          op_b_q         <= '0;
          result_q       <= rd_data;
          retire_q       <= 1'b1;
          branch_valid_q <= br_q;
          branch_taken_q <= br_q & logic_data;
          illegal_q      <= ill_q;
        end
        StRetire: begin
          state_q        <= StIdle;
          retire_q       <= 1'b0;
          branch_valid_q <= 1'b0;
          branch_taken_q <= 1'b0;
          illegal_q      <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign func3        = code_q[2:0];
  assign func7        = code_q[9:3];
  assign rs1_data     = op_a_q;
  assign rs2_data     = op_b_q;
  assign retire_valid = retire_q;
  assign branch_valid = branch_valid_q;
  assign branch_taken = branch_taken_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] rs1_data, rs2_data, rd_data, dbg_data;
  logic        logic_data;
  logic        retire_valid, branch_valid, branch_taken, illegal;
  logic [4:0]  dbg_addr = 5'd0;

  always #5 clk = ~clk;

  alu_issue #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .func3        (func3),
    .func7        (func7),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .rd_data      (rd_data),
    .logic_data   (logic_data),
    .retire_valid (retire_valid),
    .branch_valid (branch_valid),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Behavioural ALU answering whatever request the DUT presents.
  logic force_en = 1'b0;
  logic force_val = 1'b0;
  always_comb begin
    rd_data    = 32'd0;
    logic_data = 1'b0;
    case ({func7, func3})
      {7'h00, 3'd0}: rd_data = rs1_data + rs2_data;
      {7'h20, 3'd0}: rd_data = rs1_data - rs2_data;
      {7'h00, 3'd1}: rd_data = rs1_data << rs2_data[4:0];
      {7'h00, 3'd2}: rd_data = {31'd0, $signed(rs1_data) < $signed(rs2_data)};
      {7'h00, 3'd3}: rd_data = {31'd0, rs1_data < rs2_data};
      {7'h00, 3'd4}: rd_data = rs1_data ^ rs2_data;
      {7'h00, 3'd5}: rd_data = rs1_data >> rs2_data[4:0];
      {7'h20, 3'd5}: rd_data = 32'($signed(rs1_data) >>> rs2_data[4:0]);
      {7'h00, 3'd6}: rd_data = rs1_data | rs2_data;
      {7'h00, 3'd7}: rd_data = rs1_data & rs2_data;
      {7'h40, 3'd4}: logic_data = (rs1_data == rs2_data);
      {7'h40, 3'd6}: logic_data = (rs1_data != rs2_data);
      {7'h40, 3'd1}: logic_data = ($signed(rs1_data) < $signed(rs2_data));
      {7'h60, 3'd5}: logic_data = ($signed(rs1_data) >= $signed(rs2_data));
      {7'h40, 3'd7}: logic_data = (rs1_data < rs2_data);
      {7'h40, 3'd5}: logic_data = (rs1_data >= rs2_data);
      default:       rd_data = 32'd0;
    endcase
    if (force_en) logic_data = force_val;
  end

  typedef struct {
    logic [31:0] ins;
    logic [9:0]  code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        br;
    logic        taken;
    logic        ill;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] rf_model [32];
  logic [9:0]  legal_r [10] = '{10'h000, 10'h100, 10'h001, 10'h002, 10'h003,
                                10'h004, 10'h005, 10'h105, 10'h006, 10'h007};
  logic [6:0]  other_ops [8] = '{7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111,
                                 7'b1101111, 7'b1100111, 7'b0000000, 7'b1110011};

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] b_type(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, 5'd0, 7'b1100011};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input logic [9:0] code,
                              input logic [31:0] a, input logic [31:0] b, input logic wr,
                              input logic [31:0] val, input logic br, input logic taken,
                              input logic ill);
    vec_t v;
    v.ins = ins; v.code = code; v.op_a = a; v.op_b = b; v.wr = wr;
    v.rd = ins[11:7]; v.val = val; v.br = br; v.taken = taken; v.ill = ill;
    return v;
  endfunction

  // Instruction-level reference: RV32I semantics on the model register file.
  function automatic vec_t ref_exec(input logic [31:0] ins);
    vec_t v;
    logic [31:0] a, b, imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh;
    f3 = ins[14:12]; f7 = ins[31:25]; sh = ins[24:20];
    a = rf_model[ins[19:15]]; b = rf_model[ins[24:20]];
    imm = {{20{ins[31]}}, ins[31:20]};
    v = mk(ins, 10'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    case (ins[6:0])
      7'b0110011: begin
        v.code = {f7, f3}; v.op_a = a; v.op_b = b; v.wr = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: v.val = a + b;
          {7'h20, 3'd0}: v.val = a - b;
          {7'h00, 3'd1}: v.val = a << b[4:0];
          {7'h00, 3'd2}: v.val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd3}: v.val = (a < b) ? 32'd1 : 32'd0;
          {7'h00, 3'd4}: v.val = a ^ b;
          {7'h00, 3'd5}: v.val = a >> b[4:0];
          {7'h20, 3'd5}: v.val = 32'($signed(a) >>> b[4:0]);
          {7'h00, 3'd6}: v.val = a | b;
          {7'h00, 3'd7}: v.val = a & b;
          default:       v.ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        v.op_a = a; v.wr = 1'b1;
        if (f3 == 3'd1) begin
          v.op_b = {27'd0, sh}; v.code = {7'h00, 3'd1}; v.val = a << sh;
        end else if (f3 == 3'd5) begin
          v.op_b = {27'd0, sh};
          if (ins[30]) begin
            v.code = {7'h20, 3'd5}; v.val = 32'($signed(a) >>> sh);
          end else begin
            v.code = {7'h00, 3'd5}; v.val = a >> sh;
          end
        end else begin
          v.op_b = imm; v.code = {7'h00, f3};
          case (f3)
            3'd0:    v.val = a + imm;
            3'd2:    v.val = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            3'd3:    v.val = (a < imm) ? 32'd1 : 32'd0;
            3'd4:    v.val = a ^ imm;
            3'd6:    v.val = a | imm;
            default: v.val = a & imm;
          endcase
        end
      end
      7'b1100011: begin
        v.op_a = a; v.op_b = b; v.br = 1'b1;
        case (f3)
          3'd0:    begin v.code = {7'h40, 3'd4}; v.taken = (a == b); end
          3'd1:    begin v.code = {7'h40, 3'd6}; v.taken = (a != b); end
          3'd4:    begin v.code = {7'h40, 3'd1}; v.taken = ($signed(a) < $signed(b)); end
          3'd5:    begin v.code = {7'h60, 3'd5}; v.taken = ($signed(a) >= $signed(b)); end
          3'd6:    begin v.code = {7'h40, 3'd7}; v.taken = (a < b); end
          3'd7:    begin v.code = {7'h40, 3'd5}; v.taken = (a >= b); end
          default: v.ill = 1'b1;
        endcase
      end
      default: v.ill = 1'b1;
    endcase
    if (v.ill) begin
      v.code = 10'd0; v.wr = 1'b0; v.br = 1'b0; v.taken = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [9:0]  c;
    rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7)); f3 = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1: begin
        c = legal_r[$urandom_range(0, 9)];
        return r_type(c[9:3], rs2, rs1, c[2:0], rd);
      end
      2:       return r_type(7'($urandom), rs2, rs1, f3, rd);
      3, 4, 5: return i_type(imm, rs1, f3, rd);
      6, 7:    return b_type(f3, rs1, rs2);
      8:       return {25'($urandom), other_ops[$urandom_range(0, 7)]};
      default: return i_type(imm, 5'd0, 3'd0, rd);
    endcase
  endfunction

  task automatic sweep(input string name);
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      check($sformatf("%s x%0d", name, r), 80'(dbg_data), 80'(rf_model[r]));
    end
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT idle; leaves at the first IDLE negedge after retire.
  task automatic run_instr(input vec_t v, input string name);
    int n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({name, " in_ready"}, 80'(in_ready), 80'(1));
    in_valid = 1'b1;
    instr    = v.ins;
    @(negedge clk);  // EXEC
    instr = $urandom();  // must be ignored while busy
    check({name, " busy"}, 80'(in_ready), 80'(0));
    check({name, " code"}, 80'({func7, func3}), 80'(v.code));
    if (!v.ill) check({name, " operands"}, 80'({rs1_data, rs2_data}), 80'({v.op_a, v.op_b}));
    check({name, " exec status"},
          80'({retire_valid, branch_valid, branch_taken, illegal}), 80'(0));
    @(negedge clk);  // RETIRE
    check({name, " retire"}, 80'({retire_valid, branch_valid, branch_taken, illegal}),
          80'({1'b1, v.br, v.taken, v.ill}));
    check({name, " req idle"}, 80'({func7, func3, rs1_data, rs2_data}), 80'(0));
    @(negedge clk);  // IDLE
    in_valid = 1'b0;
    check({name, " pulse"}, 80'({retire_valid, branch_valid, branch_taken, illegal}), 80'(0));
    if (v.wr && v.rd != 5'd0) rf_model[v.rd] = v.val;
    if (v.wr) begin
      dbg_addr = v.rd;
      #1;
      check({name, " dbg rd"}, 80'(dbg_data), 80'(rf_model[v.rd]));
    end else begin
      sweep({name, " rf"});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500000");
    $fatal(1);
  end

  vec_t tbl [14];
  vec_t v;

  initial begin
    for (int r = 0; r < 32; r++) rf_model[r] = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset outs", 80'({retire_valid, branch_valid, branch_taken, illegal, func7, func3}),
          80'(0));
    check("reset ops", 80'({rs1_data, rs2_data}), 80'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", 80'(in_ready), 80'(1));
    sweep("reset rf");

    tbl[0]  = mk(i_type(12'd5, 5'd0, 3'd0, 5'd1), 10'h000, 32'd0, 32'd5, 1'b1, 32'd5,
                 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 10'h000, 32'd5, 32'd5, 1'b1, 32'd10,
                 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(i_type(12'd1, 5'd0, 3'd0, 5'd3), 10'h000, 32'd0, 32'd1, 1'b1, 32'd1,
                 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(i_type({7'h00, 5'd31}, 5'd3, 3'd1, 5'd3), {7'h00, 3'd1}, 32'd1, 32'd31, 1'b1,
                 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(i_type({7'h20, 5'd4}, 5'd3, 3'd5, 5'd4), {7'b0100000, 3'b101}, 32'h8000_0000,
                 32'd4, 1'b1, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(i_type(12'hFFF, 5'd0, 3'd0, 5'd5), 10'h000, 32'd0, 32'hFFFF_FFFF, 1'b1,
                 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(i_type(12'd1, 5'd0, 3'd0, 5'd6), 10'h000, 32'd0, 32'd1, 1'b1, 32'd1,
                 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(b_type(3'd4, 5'd5, 5'd6), {7'b1000000, 3'b001}, 32'hFFFF_FFFF, 32'd1, 1'b0,
                 32'd0, 1'b1, 1'b1, 1'b0);
    tbl[8]  = mk(b_type(3'd7, 5'd5, 5'd6), {7'b1000000, 3'b101}, 32'hFFFF_FFFF, 32'd1, 1'b0,
                 32'd0, 1'b1, 1'b1, 1'b0);
    tbl[9]  = mk(b_type(3'd5, 5'd5, 5'd6), {7'b1100000, 3'b101}, 32'hFFFF_FFFF, 32'd1, 1'b0,
                 32'd0, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(i_type(12'd7, 5'd0, 3'd0, 5'd0), 10'h000, 32'd0, 32'd7, 1'b1, 32'd0,
                 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(32'h0000_0000, 10'h000, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(b_type(3'd2, 5'd5, 5'd6), 10'h000, 32'd0, 32'd0, 1'b0, 32'd0,
                 1'b0, 1'b0, 1'b1);
    tbl[13] = mk(r_type(7'h01, 5'd6, 5'd5, 3'd0, 5'd7), 10'h000, 32'd0, 32'd0, 1'b0, 32'd0,
                 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // branch_taken follows the ALU's answer, not the DUT's own view of the operands.
    force_en = 1'b1; force_val = 1'b0;
    v = ref_exec(b_type(3'd7, 5'd5, 5'd6));
    v.taken = 1'b0;
    run_instr(v, "bgeu forced0");
    force_val = 1'b1;
    v = ref_exec(b_type(3'd0, 5'd5, 5'd6));
    v.taken = 1'b1;
    run_instr(v, "beq forced1");
    force_en = 1'b0;

    // Reset during EXEC of ADDI x7,x0,9 aborts it.
    in_valid = 1'b1;
    instr    = i_type(12'd9, 5'd0, 3'd0, 5'd7);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort exec op_b", 80'(rs2_data), 80'(9));
    rst_n = 1'b0;
    #1;
    check("abort async outs",
          80'({retire_valid, branch_valid, branch_taken, illegal, func7, func3}), 80'(0));
    check("abort async ops", 80'({rs1_data, rs2_data}), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) rf_model[r] = 32'd0;
    check("abort in_ready", 80'(in_ready), 80'(1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort quiet%0d", c),
            80'({retire_valid, branch_valid, illegal, func7, func3, rs2_data}), 80'(0));
    end
    sweep("abort rf");

    // Randomized instruction stream against the reference model.
    for (int i = 0; i < 300; i++) begin
      v = ref_exec(gen_instr());
      run_instr(v, $sformatf("rand%0d", i));
    end
    sweep("final rf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
